tl_rx_fc_update_sched: RTL and testbench
========================================

# tl_rx_fc_update_sched

Receive-side UpdateFC scheduler for the TL RX flow-control path. It collects update requests from the six per-type credit counters (P/NP/CPL × hdr/data), grouped into three FC classes. It also generates periodic refresh requests from an internal timer. It round-robin arbitrates the three classes and hands one UpdateFC DLLP request at a time to the DLL over a valid/ready handshake, carrying a snapshot of the allocated-credit values and scale factors.

## Interface
- HDR_FIELD_SIZE, 8, width of header credit fields (8/10/12)
- DATA_FIELD_SIZE, 12, width of data credit fields (12/14/16)
- UPDATE_TIMER, 1024, refresh period in clk cycles (≥4)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dll_init  in  1  DLL FC initialization in progress; scheduler held idle
- upd_req  in  3  per-class update pulse, bit0 P, bit1 NP, bit2 CPL (hdr_update|data_update of that class)
- creds_alloc_hdr_p/np/cpl  in  HDR_FIELD_SIZE each  current allocated header credits
- creds_alloc_data_p/np/cpl  in  DATA_FIELD_SIZE each  current allocated data credits
- hdr_scale, data_scale  in  6 each  packed 2-bit scale per class, [1:0] P, [3:2] NP, [5:4] CPL
- fc_dllp_valid  out  1  UpdateFC request valid
- fc_dllp_ready  in  1  DLL accepts request
- fc_dllp_type  out  2  00 P, 01 NP, 10 CPL
- fc_dllp_hdr  out  HDR_FIELD_SIZE  HdrFC snapshot
- fc_dllp_data  out  DATA_FIELD_SIZE  DataFC snapshot
- fc_dllp_hdr_scale, fc_dllp_data_scale  out  2 each  scale snapshot

## Operation
- pending[2:0] register. Bit set by upd_req[i] or by timer expiry (all three bits). Bit cleared when class i is accepted (valid&ready). Set and clear in the same cycle: set wins.
- Timer: counts 0..UPDATE_TIMER-1 while dll_init=0. On reaching UPDATE_TIMER-1 it wraps to 0 and sets pending=3'b111. Held at 0 while dll_init=1.
- FSM states:
  - IDLE (reset state): if dll_init=0, go to ARB.
  - ARB: if pending≠0, grant the first set bit after last_grant (round-robin order P→NP→CPL→P), latch type/hdr/data/scales of the granted class, go to SEND. Otherwise stay.
  - SEND: fc_dllp_valid=1. On ready, clear that pending bit, set last_grant=granted class, go to ARB.
- While valid=1, all payload outputs are stable. Payload is not refreshed while waiting for ready.
- dll_init=1 in any state: next state IDLE; pending, timer and valid are cleared; the outstanding request is dropped; last_grant is reset to CPL.
- Credit values are passed through unmodified. Width is fixed by the parameters, with no truncation or scaling arithmetic.

## Timing
- Reset values: fc_dllp_valid=0, all payload outputs 0, pending=0, timer=0, last_grant=CPL (so P wins first).
- Latency: upd_req pulse at cycle N → pending visible at N+1 → grant in ARB at N+1 → fc_dllp_valid=1 at N+2.
- Throughput: at most one DLLP every 2 cycles (mandatory ARB cycle after each acceptance).
- ready is sampled only while valid=1. ready with valid=0 is ignored.
- upd_req for the in-flight class during SEND sets its bit again after acceptance. A fresh snapshot is then sent later.
- dll_init deassert at cycle M → ARB at M+1. The timer starts counting at M+1.

## Structure
- Shared package tl_rx_fc_pkg:
  - class encodings FC_P=2'b00, FC_NP=2'b01, FC_CPL=2'b10
  - scale encodings
  - FSM state localparams
- Sub-module tl_rx_fc_rr_arb:
  - 3-way round-robin grant from pending and last_grant, purely combinational
  - one-hot grant plus encoded class output
- The top level holds the timer, pending register, FSM and payload registers.

## Test plan
- Reset, then dll_init 1→0, upd_req=3'b001 at cycle 10 → valid at 12, type=00, hdr/data equal to P inputs; ready at 12 → valid=0 at 13, pending[0]=0.
- upd_req=3'b111 in one cycle, ready tied 1 → grants P, NP, CPL at cycles N+2, N+4, N+6; then idle.
- ready held 0 for 5 cycles while creds_alloc_hdr_p changes → payload stays at the grant-time value until accepted.
- UPDATE_TIMER=16, no upd_req → a P/NP/CPL burst every 16 cycles; timer stays at 0 while dll_init=1.
- dll_init asserted during SEND with ready=0 → valid=0 next cycle, pending=0; after deassert, no DLLP until the next upd_req or timer expiry.
- upd_req[1] in the same cycle NP is accepted → pending[1] stays set; a second NP DLLP follows with fresh values.

Source files
------------

// File: rtl/tl_rx_fc_update_sched_pkg.sv
// Shared encodings for the TL RX flow-control update path: FC classes,
// scale factors, scheduler FSM states and small class helpers.
package tl_rx_fc_pkg;

   typedef logic [1:0] fc_cls_t;
   localparam fc_cls_t FC_P   = 2'b00;
   localparam fc_cls_t FC_NP  = 2'b01;
   localparam fc_cls_t FC_CPL = 2'b10;

   typedef logic [1:0] fc_scale_t;
   localparam fc_scale_t SCALE_NONE = 2'b00;
   localparam fc_scale_t SCALE_X1   = 2'b01;
   localparam fc_scale_t SCALE_X4   = 2'b10;
   localparam fc_scale_t SCALE_X16  = 2'b11;

   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE = 2'b00;
   localparam fsm_state_t ST_ARB  = 2'b01;
   localparam fsm_state_t ST_SEND = 2'b10;

   // Round-robin successor; any unused encoding falls back to P.
   function automatic fc_cls_t next_cls(input fc_cls_t cls);
      case (cls)
         FC_P:    return FC_NP;
         FC_NP:   return FC_CPL;
         default: return FC_P;
      endcase
   endfunction

   function automatic fc_scale_t cls_scale(input logic [5:0] packed_scale, input fc_cls_t cls);
      case (cls)
         FC_NP:   return packed_scale[3:2];
         FC_CPL:  return packed_scale[5:4];
         default: return packed_scale[1:0];
      endcase
   endfunction

endpackage

// File: rtl/tl_rx_fc_update_sched_if.sv
// UpdateFC request channel between the RX scheduler (master) and the DLL (slave).
interface tl_rx_fc_update_sched_if #(
   parameter int HDR_FIELD_SIZE  = 8,
   parameter int DATA_FIELD_SIZE = 12
);
   logic                       fc_dllp_valid;
   logic                       fc_dllp_ready;
   logic [1:0]                 fc_dllp_type;
   logic [HDR_FIELD_SIZE-1:0]  fc_dllp_hdr;
   logic [DATA_FIELD_SIZE-1:0] fc_dllp_data;
   logic [1:0]                 fc_dllp_hdr_scale;
   logic [1:0]                 fc_dllp_data_scale;

   modport master (
      output fc_dllp_valid, fc_dllp_type, fc_dllp_hdr, fc_dllp_data,
             fc_dllp_hdr_scale, fc_dllp_data_scale,
      input  fc_dllp_ready
   );

   modport slave (
      input  fc_dllp_valid, fc_dllp_type, fc_dllp_hdr, fc_dllp_data,
             fc_dllp_hdr_scale, fc_dllp_data_scale,
      output fc_dllp_ready
   );
endinterface

// File: rtl/tl_rx_fc_update_sched_rr_arb.sv
// Combinational 3-way round-robin arbiter over the FC classes, starting the
// search at the class after last_grant.
module tl_rx_fc_rr_arb
   import tl_rx_fc_pkg::*;
(
   input  logic [2:0] pending,
   input  fc_cls_t    last_grant,
   output logic [2:0] gnt_oh,
   output fc_cls_t    gnt_cls
);

   fc_cls_t cand;
   logic    found;

   always_comb begin
      gnt_oh  = '0;
      gnt_cls = FC_P;
      found   = 1'b0;
      cand    = next_cls(last_grant);
      for (int k = 0; k < 3; k++) begin
         if (!found && pending[cand]) begin
            gnt_oh[cand] = 1'b1;
            gnt_cls      = cand;
            found        = 1'b1;
         end
         cand = next_cls(cand);
      end
   end

endmodule

// File: rtl/tl_rx_fc_update_sched.sv
// Receive-side UpdateFC scheduler: collects per-class update requests and
// periodic refreshes, arbitrates them and issues one DLLP request at a time.
module tl_rx_fc_update_sched
   import tl_rx_fc_pkg::*;
#(
   parameter int HDR_FIELD_SIZE  = 8,
   parameter int DATA_FIELD_SIZE = 12,
   parameter int UPDATE_TIMER    = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dll_init,
   input  logic [2:0]                 upd_req,
   input  logic [HDR_FIELD_SIZE-1:0]  creds_alloc_hdr_p,
   input  logic [HDR_FIELD_SIZE-1:0]  creds_alloc_hdr_np,
   input  logic [HDR_FIELD_SIZE-1:0]  creds_alloc_hdr_cpl,
   input  logic [DATA_FIELD_SIZE-1:0] creds_alloc_data_p,
   input  logic [DATA_FIELD_SIZE-1:0] creds_alloc_data_np,
   input  logic [DATA_FIELD_SIZE-1:0] creds_alloc_data_cpl,
   input  logic [5:0]                 hdr_scale,
   input  logic [5:0]                 data_scale,
   tl_rx_fc_update_sched_if.master    fc_dllp
);

   localparam int TW = (UPDATE_TIMER > 1) ? $clog2(UPDATE_TIMER) : 1;

   fsm_state_t                 state, state_nxt;
   logic [TW-1:0]              timer;
   logic                       tmr_exp;
   logic [2:0]                 pending;
   logic [2:0]                 clr;
   fc_cls_t                    last_grant;
   logic [2:0]                 gnt_oh;
   fc_cls_t                    gnt_cls;
   logic                       grant_en;
   logic                       accept;
   logic                       valid;
   fc_cls_t                    type_q;
   logic [HDR_FIELD_SIZE-1:0]  hdr_q, hdr_sel;
   logic [DATA_FIELD_SIZE-1:0] data_q, data_sel;
   fc_scale_t                  hsc_q, dsc_q;

   tl_rx_fc_rr_arb u_arb (
      .pending    (pending),
      .last_grant (last_grant),
      .gnt_oh     (gnt_oh),
      .gnt_cls    (gnt_cls)
   );

   // Refresh timer runs only once the scheduler has left IDLE.
   assign tmr_exp = !dll_init && (state != ST_IDLE) && (timer == TW'(UPDATE_TIMER - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              timer <= '0;
      else if (dll_init || state == ST_IDLE) timer <= '0;
      else if (tmr_exp)                      timer <= '0;
      else                                   timer <= timer + 1'b1;
   end

   assign clr = accept ? (3'b001 << type_q) : 3'b000;

   // A new request arriving with the acceptance of the same class wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          pending <= '0;
      else if (dll_init) pending <= '0;
      else               pending <= (pending & ~clr) | upd_req | {3{tmr_exp}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          last_grant <= FC_CPL;
      else if (dll_init) last_grant <= FC_CPL;
      else if (accept)   last_grant <= type_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (dll_init) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_ARB;
            ST_ARB:  if (|gnt_oh) state_nxt = ST_SEND;
            ST_SEND: if (fc_dllp.fc_dllp_ready) state_nxt = ST_ARB;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      valid    = (state == ST_SEND);
      grant_en = (state == ST_ARB) && !dll_init && (|gnt_oh);
      accept   = (state == ST_SEND) && !dll_init && fc_dllp.fc_dllp_ready;
   end

   always_comb begin
      case (gnt_cls)
         FC_NP: begin
            hdr_sel  = creds_alloc_hdr_np;
            data_sel = creds_alloc_data_np;
         end
         FC_CPL: begin
            hdr_sel  = creds_alloc_hdr_cpl;
            data_sel = creds_alloc_data_cpl;
         end
         default: begin
            hdr_sel  = creds_alloc_hdr_p;
            data_sel = creds_alloc_data_p;
         end
      endcase
   end

   // Snapshot taken only at grant; held untouched until the DLL accepts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         type_q <= FC_P;
         hdr_q  <= '0;
         data_q <= '0;
         hsc_q  <= SCALE_NONE;
         dsc_q  <= SCALE_NONE;
      end else if (grant_en) begin
         type_q <= gnt_cls;
         hdr_q  <= hdr_sel;
         data_q <= data_sel;
         hsc_q  <= cls_scale(hdr_scale, gnt_cls);
         dsc_q  <= cls_scale(data_scale, gnt_cls);
      end
   end

   assign fc_dllp.fc_dllp_valid      = valid;
   assign fc_dllp.fc_dllp_type       = type_q;
   assign fc_dllp.fc_dllp_hdr        = hdr_q;
   assign fc_dllp.fc_dllp_data       = data_q;
   assign fc_dllp.fc_dllp_hdr_scale  = hsc_q;
   assign fc_dllp.fc_dllp_data_scale = dsc_q;

endmodule

// File: tb/tb_tl_rx_fc_update_sched.sv
// Directed bench for the UpdateFC scheduler: one default-period instance for
// handshake scenarios and one short-period instance for the refresh timer.
module tb_tl_rx_fc_update_sched;
   import tl_rx_fc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dll_init, dll_init_t;
   logic [2:0]  upd_req, upd_req_t;
   logic [7:0]  hdr_p, hdr_np, hdr_cpl;
   logic [11:0] data_p, data_np, data_cpl;
   logic [5:0]  hdr_scale, data_scale;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   tl_rx_fc_update_sched_if #(.HDR_FIELD_SIZE(8), .DATA_FIELD_SIZE(12)) dll_if ();
   tl_rx_fc_update_sched_if #(.HDR_FIELD_SIZE(8), .DATA_FIELD_SIZE(12)) tmr_if ();

   tl_rx_fc_update_sched #(.HDR_FIELD_SIZE(8), .DATA_FIELD_SIZE(12), .UPDATE_TIMER(1024)) u_dut (
      .clk(clk), .rst(rst), .dll_init(dll_init), .upd_req(upd_req),
      .creds_alloc_hdr_p(hdr_p), .creds_alloc_hdr_np(hdr_np), .creds_alloc_hdr_cpl(hdr_cpl),
      .creds_alloc_data_p(data_p), .creds_alloc_data_np(data_np), .creds_alloc_data_cpl(data_cpl),
      .hdr_scale(hdr_scale), .data_scale(data_scale), .fc_dllp(dll_if.master)
   );

   tl_rx_fc_update_sched #(.HDR_FIELD_SIZE(8), .DATA_FIELD_SIZE(12), .UPDATE_TIMER(16)) u_tmr (
      .clk(clk), .rst(rst), .dll_init(dll_init_t), .upd_req(upd_req_t),
      .creds_alloc_hdr_p(hdr_p), .creds_alloc_hdr_np(hdr_np), .creds_alloc_hdr_cpl(hdr_cpl),
      .creds_alloc_data_p(data_p), .creds_alloc_data_np(data_np), .creds_alloc_data_cpl(data_cpl),
      .hdr_scale(hdr_scale), .data_scale(data_scale), .fc_dllp(tmr_if.master)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse dll_init; on return the DUT has just entered ARB with a fresh timer.
   task automatic init_link;
      dll_init = 1'b1;
      upd_req  = 3'b000;
      dll_if.fc_dllp_ready = 1'b0;
      tick;
      tick;
      dll_init = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %0b expected 0", dll_if.fc_dllp_valid);
      end
      checks++;
      if ({dll_if.fc_dllp_type, dll_if.fc_dllp_hdr, dll_if.fc_dllp_data,
           dll_if.fc_dllp_hdr_scale, dll_if.fc_dllp_data_scale} !== 26'h0) begin
         failures++; $display("FAIL reset_payload: got type=%0h hdr=%0h data=%0h expected all 0",
                              dll_if.fc_dllp_type, dll_if.fc_dllp_hdr, dll_if.fc_dllp_data);
      end
      checks++;
      if (u_dut.pending !== 3'b000 || u_dut.timer !== '0) begin
         failures++; $display("FAIL reset_pending_timer: got pending=%0b timer=%0d expected 0/0",
                              u_dut.pending, u_dut.timer);
      end
      checks++;
      if (u_dut.last_grant !== FC_CPL) begin
         failures++; $display("FAIL reset_last_grant: got %0h expected 2", u_dut.last_grant);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      tick;
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0 || u_dut.timer !== '0) begin
         failures++; $display("FAIL init_idle: got valid=%0b timer=%0d expected 0/0",
                              dll_if.fc_dllp_valid, u_dut.timer);
      end
   endtask

   task automatic test_single;
      init_link;
      hdr_p = 8'h5A; data_p = 12'h3C1;
      hdr_scale = 6'b11_10_01; data_scale = 6'b01_11_10;
      tick;
      upd_req = 3'b001;
      tick;
      upd_req = 3'b000;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0 || u_dut.pending !== 3'b001) begin
         failures++; $display("FAIL single_n1: got valid=%0b pending=%0b expected 0/001",
                              dll_if.fc_dllp_valid, u_dut.pending);
      end
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b1 || dll_if.fc_dllp_type !== 2'b00) begin
         failures++; $display("FAIL single_valid: got valid=%0b type=%0h expected 1/0",
                              dll_if.fc_dllp_valid, dll_if.fc_dllp_type);
      end
      checks++;
      if (dll_if.fc_dllp_hdr !== 8'h5A || dll_if.fc_dllp_data !== 12'h3C1) begin
         failures++; $display("FAIL single_payload: got hdr=%0h data=%0h expected 5a/3c1",
                              dll_if.fc_dllp_hdr, dll_if.fc_dllp_data);
      end
      checks++;
      if (dll_if.fc_dllp_hdr_scale !== 2'b01 || dll_if.fc_dllp_data_scale !== 2'b10) begin
         failures++; $display("FAIL single_scale: got hs=%0b ds=%0b expected 01/10",
                              dll_if.fc_dllp_hdr_scale, dll_if.fc_dllp_data_scale);
      end
      dll_if.fc_dllp_ready = 1'b1;
      tick;
      dll_if.fc_dllp_ready = 1'b0;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0 || u_dut.pending !== 3'b000) begin
         failures++; $display("FAIL single_accept: got valid=%0b pending=%0b expected 0/000",
                              dll_if.fc_dllp_valid, u_dut.pending);
      end
   endtask

   task automatic test_burst;
      logic [7:0] exp_hdr [3];
      logic       exp_v;
      int         idx;
      init_link;
      hdr_p = 8'h10; hdr_np = 8'h20; hdr_cpl = 8'h30;
      data_p = 12'h100; data_np = 12'h200; data_cpl = 12'h300;
      exp_hdr[0] = 8'h10; exp_hdr[1] = 8'h20; exp_hdr[2] = 8'h30;
      dll_if.fc_dllp_ready = 1'b1;
      upd_req = 3'b111;
      tick;
      upd_req = 3'b000;
      for (int k = 1; k <= 8; k++) begin
         exp_v = (k == 2 || k == 4 || k == 6);
         idx   = k / 2 - 1;
         checks++;
         if (dll_if.fc_dllp_valid !== exp_v) begin
            failures++; $display("FAIL burst_valid_c%0d: got %0b expected %0b", k, dll_if.fc_dllp_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (dll_if.fc_dllp_type !== 2'(idx) || dll_if.fc_dllp_hdr !== exp_hdr[idx]) begin
               failures++; $display("FAIL burst_payload_c%0d: got type=%0h hdr=%0h expected %0h/%0h",
                                    k, dll_if.fc_dllp_type, dll_if.fc_dllp_hdr, idx, exp_hdr[idx]);
            end
         end
         tick;
      end
      dll_if.fc_dllp_ready = 1'b0;
      checks++;
      if (u_dut.pending !== 3'b000) begin
         failures++; $display("FAIL burst_drained: got pending=%0b expected 000", u_dut.pending);
      end
   endtask

   task automatic test_hold;
      init_link;
      hdr_p = 8'h11;
      upd_req = 3'b001;
      tick;
      upd_req = 3'b000;
      tick;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (dll_if.fc_dllp_valid !== 1'b1 || dll_if.fc_dllp_hdr !== 8'h11) begin
            failures++; $display("FAIL hold_c%0d: got valid=%0b hdr=%0h expected 1/11",
                                 k, dll_if.fc_dllp_valid, dll_if.fc_dllp_hdr);
         end
         hdr_p = 8'h22 + 8'(k);
         tick;
      end
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b1 || dll_if.fc_dllp_hdr !== 8'h11) begin
         failures++; $display("FAIL hold_final: got valid=%0b hdr=%0h expected 1/11",
                              dll_if.fc_dllp_valid, dll_if.fc_dllp_hdr);
      end
      dll_if.fc_dllp_ready = 1'b1;
      tick;
      dll_if.fc_dllp_ready = 1'b0;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0) begin
         failures++; $display("FAIL hold_accept: got valid=%0b expected 0", dll_if.fc_dllp_valid);
      end
   endtask

   task automatic test_timer;
      logic exp_v;
      int   off;
      dll_init = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick;
         checks++;
         if (u_tmr.timer !== '0 || tmr_if.fc_dllp_valid !== 1'b0) begin
            failures++; $display("FAIL timer_held_c%0d: got timer=%0d valid=%0b expected 0/0",
                                 k, u_tmr.timer, tmr_if.fc_dllp_valid);
         end
      end
      dll_init_t = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         tick;
         exp_v = (c == 18 || c == 20 || c == 22 || c == 34 || c == 36 || c == 38);
         checks++;
         if (tmr_if.fc_dllp_valid !== exp_v) begin
            failures++; $display("FAIL timer_valid_c%0d: got %0b expected %0b", c, tmr_if.fc_dllp_valid, exp_v);
         end
         if (exp_v) begin
            off = (c < 34) ? (c - 18) : (c - 34);
            checks++;
            if (tmr_if.fc_dllp_type !== 2'(off / 2)) begin
               failures++; $display("FAIL timer_type_c%0d: got %0h expected %0h", c, tmr_if.fc_dllp_type, off / 2);
            end
         end
         if (c == 1 || c == 17) begin
            checks++;
            if (u_tmr.timer !== '0) begin
               failures++; $display("FAIL timer_wrap_c%0d: got %0d expected 0", c, u_tmr.timer);
            end
         end
      end
      dll_init_t = 1'b1;
      tick;
      tick;
      checks++;
      if (u_tmr.timer !== '0 || u_tmr.pending !== 3'b000) begin
         failures++; $display("FAIL timer_reinit: got timer=%0d pending=%0b expected 0/000",
                              u_tmr.timer, u_tmr.pending);
      end
   endtask

   task automatic test_abort;
      init_link;
      upd_req = 3'b001;
      tick;
      upd_req = 3'b000;
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b1) begin
         failures++; $display("FAIL abort_send: got valid=%0b expected 1", dll_if.fc_dllp_valid);
      end
      dll_init = 1'b1;
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0 || u_dut.pending !== 3'b000 || u_dut.last_grant !== FC_CPL) begin
         failures++; $display("FAIL abort_drop: got valid=%0b pending=%0b last=%0h expected 0/000/2",
                              dll_if.fc_dllp_valid, u_dut.pending, u_dut.last_grant);
      end
      dll_init = 1'b0;
      tick;
      for (int k = 0; k < 8; k++) begin
         tick;
         checks++;
         if (dll_if.fc_dllp_valid !== 1'b0) begin
            failures++; $display("FAIL abort_quiet_c%0d: got valid=%0b expected 0", k, dll_if.fc_dllp_valid);
         end
      end
      upd_req = 3'b010;
      tick;
      upd_req = 3'b000;
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b1 || dll_if.fc_dllp_type !== 2'b01) begin
         failures++; $display("FAIL abort_resume: got valid=%0b type=%0h expected 1/1",
                              dll_if.fc_dllp_valid, dll_if.fc_dllp_type);
      end
      dll_if.fc_dllp_ready = 1'b1;
      tick;
      dll_if.fc_dllp_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      init_link;
      hdr_np = 8'h40; data_np = 12'h400;
      upd_req = 3'b010;
      tick;
      upd_req = 3'b000;
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b1 || dll_if.fc_dllp_type !== 2'b01 || dll_if.fc_dllp_hdr !== 8'h40) begin
         failures++; $display("FAIL b2b_first: got valid=%0b type=%0h hdr=%0h expected 1/1/40",
                              dll_if.fc_dllp_valid, dll_if.fc_dllp_type, dll_if.fc_dllp_hdr);
      end
      dll_if.fc_dllp_ready = 1'b1;
      upd_req = 3'b010;
      hdr_np = 8'h41; data_np = 12'h401;
      tick;
      upd_req = 3'b000;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0 || u_dut.pending !== 3'b010) begin
         failures++; $display("FAIL b2b_reset_win: got valid=%0b pending=%0b expected 0/010",
                              dll_if.fc_dllp_valid, u_dut.pending);
      end
      tick;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b1 || dll_if.fc_dllp_hdr !== 8'h41 || dll_if.fc_dllp_data !== 12'h401) begin
         failures++; $display("FAIL b2b_second: got valid=%0b hdr=%0h data=%0h expected 1/41/401",
                              dll_if.fc_dllp_valid, dll_if.fc_dllp_hdr, dll_if.fc_dllp_data);
      end
      tick;
      dll_if.fc_dllp_ready = 1'b0;
      checks++;
      if (dll_if.fc_dllp_valid !== 1'b0 || u_dut.pending !== 3'b000) begin
         failures++; $display("FAIL b2b_done: got valid=%0b pending=%0b expected 0/000",
                              dll_if.fc_dllp_valid, u_dut.pending);
      end
   endtask

   initial begin
      rst = 1'b0;
      dll_init = 1'b1;
      dll_init_t = 1'b1;
      upd_req = 3'b000;
      upd_req_t = 3'b000;
      hdr_p = '0; hdr_np = '0; hdr_cpl = '0;
      data_p = '0; data_np = '0; data_cpl = '0;
      hdr_scale = '0; data_scale = '0;
      dll_if.fc_dllp_ready = 1'b0;
      tmr_if.fc_dllp_ready = 1'b1;
      test_reset;
      test_single;
      test_burst;
      test_hold;
      test_timer;
      test_abort;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
